sipo_frame_ctrl: RTL
====================

Name: sipo_frame_ctrl

Overview:
- Receive-side controller that sequences a serial-in/parallel-out shift register.
- Detects a start bit on `si` and enables shifting for exactly DATA_W bits.
- Optionally checks a parity bit, then checks a stop bit.
- Hands the assembled word to a downstream consumer over a valid/ready handshake. Sits between the raw serial line and the parallel consumer logic.

Parameters:
- DATA_W, 4, number of data bits per frame; legal range 2..32.
- PAR_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- PAR_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PAR_EN=0.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- si  input  1  serial data, one bit per clk cycle; idle level is 1.
- out_data  output  DATA_W  assembled word; the first received data bit is in out_data[DATA_W-1] (MSB-first).
- out_valid  output  1  out_data, par_err and frm_err hold a word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready at a rising edge.
- par_err  output  1  parity mismatch for the held word; qualified by out_valid.
- frm_err  output  1  stop bit was 0 for the held word; qualified by out_valid.
- ovr_err  output  1  one-cycle pulse: a completed frame was dropped because the buffer was still full.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; bit counter = 0; shift register = 0.
  - out_data = 0; out_valid = 0; par_err = 0; frm_err = 0; ovr_err = 0; busy = 0.
  - Reset mid-frame discards the partial frame and any held word.
- FSM states: IDLE, SHIFT, PARITY, STOP.
  - IDLE: si=0 sampled at an edge → SHIFT, counter cleared to 0. si=1 → stay in IDLE.
  - SHIFT: each edge shifts si into the LSB (the register shifts left) and increments the counter. The edge that takes bit DATA_W-1 moves to PARITY if PAR_EN=1, else to STOP.
  - PARITY: sample si into a parity flag.
    - Expected bit = XOR of the data bits (even) or its inverse (odd).
    - Mismatch sets the pending par_err. Go to STOP.
  - STOP: sample si; si=0 sets the pending frm_err. Always go to IDLE on this edge, then deliver the word.
- Delivery (on the STOP edge):
  - Buffer free = out_valid=0, or out_valid && out_ready on this same edge.
  - Free: load out_data, par_err and frm_err; set out_valid=1.
  - Not free: keep the old word, drop the new word, ovr_err=1 for exactly one cycle.
- Handshake:
  - out_valid stays high and out_data stays stable until accepted.
  - Acceptance without a simultaneous load clears out_valid on that edge. par_err and frm_err clear with it.
  - out_ready while out_valid=0 has no effect.
- Latency:
  - A frame occupies 2+DATA_W+PAR_EN edges, counting the start edge.
  - out_valid is visible the cycle after the STOP edge.
  - A back-to-back start bit may be sampled on the first edge after STOP; no idle cycle is required.
- busy=1 in SHIFT, PARITY and STOP.
- si is assumed synchronous to clk; no synchroniser inside.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2, STOP=2'd3.
  - default widths.
  - a function for counter width, clog2(DATA_W).
- One sub-module, sipo_shreg:
  - Parameter DATA_W; ports clk, rst, shift_en, si, q.
  - Shifts left with si into the LSB when shift_en=1.
  - The controller drives shift_en high only in SHIFT.

Test Plan:
- Reset then idle: rst=0 for 12 time units, si=1 forever → all outputs 0, busy=0, no frame accepted.
- Good frame (DATA_W=4, even parity): si = 0,1,0,1,1,1(parity),1(stop), out_ready=1 → out_data=4'b1011, par_err=0, frm_err=0, out_valid high for 1 cycle.
- Errors: same frame with parity bit 0 → par_err=1. Stop bit 0 → frm_err=1. In both cases out_data=4'b1011.
- Overrun: out_ready=0; send 4'b1011 then 4'b0110 back-to-back → out_valid stays 1, out_data stays 4'b1011, ovr_err pulses once at the second STOP edge.
- Simultaneous accept/load: out_ready asserted on the same edge as the second frame's STOP → no ovr_err, out_data=4'b0110, out_valid remains 1.
- Reset mid-frame: drop rst after 2 data bits, then release; send 4'b1111 → out_data=4'b1111 with no residue, busy=0 during reset.

Source files
------------

// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared definitions for the SIPO frame controller: FSM encoding, default
// widths and the bit-counter width helper.
package sipo_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_PAR_EN  = 1;
  localparam int DEF_PAR_ODD = 0;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Serial-in/parallel-out shift register; shifts left with si entering the LSB,
// so the first bit shifted in ends up in the MSB.
module sipo_shreg #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              si,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[DATA_W-2:0], si};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Receive-side frame controller: start detect, DATA_W data bits, optional
// parity, stop check, then a single-entry valid/ready output buffer.
module sipo_frame_ctrl
  import sipo_frame_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PAR_EN  = DEF_PAR_EN,
  parameter int PAR_ODD = DEF_PAR_ODD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              par_err,
  output logic              frm_err,
  output logic              ovr_err,
  output logic              busy
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic ODD = (PAR_ODD != 0);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              par_pend;
  logic              shift_en;
  logic [DATA_W-1:0] q;
  logic              par_exp;
  logic              buf_free;

  assign shift_en = (state == SHIFT);
  assign par_exp  = (^q) ^ ODD;
  // The buffer may be reloaded on the same edge the consumer takes the old word.
  assign buf_free = !out_valid || out_ready;

  sipo_shreg #(.DATA_W(DATA_W)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .si       (si),
    .q        (q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      par_pend  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      ovr_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ovr_err <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        par_err   <= 1'b0;
        frm_err   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!si) begin
            state <= SHIFT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state <= (PAR_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_pend <= (si != par_exp);
          state    <= STOP;
        end
        STOP: begin
          state    <= IDLE;
          busy     <= 1'b0;
          par_pend <= 1'b0;
          if (buf_free) begin
            out_data  <= q;
            out_valid <= 1'b1;
            par_err   <= par_pend;
            frm_err   <= !si;
          end else begin
            ovr_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
